receiver_sampler: RTL

Parametrised UART receive-side bit-timing engine that sits between the oversampling tick generator and the receive shift register. It generalises the fixed ×16 half-bit/full-bit reload counter. It adds configurable oversampling ratio, frame format, start-bit validation, 3-tick majority voting, and per-bit strobes carrying bit index and frame status.

---
 rtl/receiver_sampler.sv | 132 +++++++++++++
 1 files changed

// File: rtl/receiver_sampler.sv
// receiver_sampler: UART receive bit-timing engine with start-bit validation,
// optional 3-tick majority vote and per-bit strobes carrying index and frame status.
module receiver_sampler #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int STOP_BITS  = 1,
    parameter int MAJORITY   = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          Rx_sample_ENABLE,
    input  logic                          rx_en,
    input  logic                          RxD,
    output logic                          sample_valid,
    output logic                          sample_bit,
    output logic [3:0]                    bit_index,
    output logic                          frame_start,
    output logic                          frame_done,
    output logic                          false_start,
    output logic                          framing_error,
    output logic                          busy,
    output logic [$clog2(OVERSAMPLE)-1:0] phase
);
    localparam int PW = $clog2(OVERSAMPLE);
    localparam logic [PW-1:0] HALF = PW'(OVERSAMPLE / 2 - 1);
    localparam logic [PW-1:0] FULL = PW'(OVERSAMPLE - 1);
    localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PARITY = 3'd3, S_STOP = 3'd4;

    logic [2:0]    r_state;
    logic [PW-1:0] r_phase;
    logic [3:0]    r_cnt;
    logic [3:0]    r_bit_index;
    logic [1:0]    r_hist;
    logic          r_err;
    logic          r_sample_valid, r_sample_bit, r_frame_start, r_frame_done, r_false_start, r_framing_error;
    logic          w_vote;

    assign w_vote = (MAJORITY != 0) ? ((RxD & r_hist[0]) | (RxD & r_hist[1]) | (r_hist[0] & r_hist[1])) : RxD;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_phase         <= '0;
            r_cnt           <= '0;
            r_bit_index     <= '0;
            r_hist          <= 2'b11;
            r_err           <= 1'b0;
            r_sample_valid  <= 1'b0;
            r_sample_bit    <= 1'b0;
            r_frame_start   <= 1'b0;
            r_frame_done    <= 1'b0;
            r_false_start   <= 1'b0;
            r_framing_error <= 1'b0;
        end else begin
            r_sample_valid  <= 1'b0;
            r_frame_start   <= 1'b0;
            r_frame_done    <= 1'b0;
            r_false_start   <= 1'b0;
            r_framing_error <= 1'b0;
            if (!rx_en) begin
                r_state     <= S_IDLE;
                r_phase     <= '0;
                r_cnt       <= '0;
                r_bit_index <= '0;
                r_hist      <= 2'b11;
                r_err       <= 1'b0;
            end else if (Rx_sample_ENABLE) begin
                r_hist <= {r_hist[0], RxD};
                if (r_state != S_IDLE && r_phase != '0)
                    r_phase <= r_phase - PW'(1);
                else
                    case (r_state)
                        S_IDLE: if (!RxD) begin
                            r_phase <= HALF;
                            r_state <= S_START;
                        end
                        S_START: if (!w_vote) begin
                            r_frame_start <= 1'b1;
                            r_phase       <= FULL;
                            r_cnt         <= '0;
                            r_state       <= S_DATA;
                        end else begin
                            r_false_start <= 1'b1;
                            r_state       <= S_IDLE;
                        end
                        S_DATA: begin
                            r_sample_valid <= 1'b1;
                            r_sample_bit   <= w_vote;
                            r_bit_index    <= r_cnt;
                            r_phase        <= FULL;
                            if (r_cnt == 4'(DATA_BITS - 1)) begin
                                r_cnt   <= '0;
                                r_state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                            end else
                                r_cnt <= r_cnt + 4'd1;
                        end
                        S_PARITY: begin
                            r_sample_valid <= 1'b1;
                            r_sample_bit   <= w_vote;
                            r_bit_index    <= 4'(DATA_BITS);
                            r_phase        <= FULL;
                            r_state        <= S_STOP;
                        end
                        S_STOP: if (r_cnt == 4'(STOP_BITS - 1)) begin
                            // phase is already 0 here, so the next tick may accept a new start edge
                            r_frame_done    <= 1'b1;
                            r_framing_error <= r_err | ~w_vote;
                            r_err           <= 1'b0;
                            r_cnt           <= '0;
                            r_state         <= S_IDLE;
                        end else begin
                            r_err   <= r_err | ~w_vote;
                            r_phase <= FULL;
                            r_cnt   <= r_cnt + 4'd1;
                        end
                        default: r_state <= S_IDLE;
                    endcase
            end
        end
    end

    assign sample_valid  = r_sample_valid;
    assign sample_bit    = r_sample_bit;
    assign bit_index     = r_bit_index;
    assign frame_start   = r_frame_start;
    assign frame_done    = r_frame_done;
    assign false_start   = r_false_start;
    assign framing_error = r_framing_error;
    assign busy          = (r_state != S_IDLE);
    assign phase         = r_phase;
endmodule
